// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_stall_ctrl                                            |
// | Description : Pipeline stall sequencer for the 5-stage MIPS core. Merges |
// |               the ID load-use request, the EX mult/div unit wait and the |
// |               data-SRAM wait into one per-register stall bus. Tracks MDU |
// |               occupancy with a watchdog and counts stall cycles.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_stall_ctrl #(
  parameter int STALL_W     = 6,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id_i,
  input  logic               mdu_start_i,
  input  logic               mdu_ready_i,
  input  logic               dmem_req_i,
  input  logic               dmem_ack_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               mdu_busy_o,
  output logic               mdu_timeout_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   lu_stall_cnt_o
);

  localparam int TMR_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(MDU_TIMEOUT - 1);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_MDU_WAIT = 2'd1;
  localparam logic [1:0] c_MEM_WAIT = 2'd2;

  // Bit i set = pipeline register i holds (0 PC .. 5 WB).
  localparam logic [STALL_W-1:0] c_STALL_MEM = STALL_W'(5'b11111);
  localparam logic [STALL_W-1:0] c_STALL_MDU = STALL_W'(4'b1111);
  localparam logic [STALL_W-1:0] c_STALL_LU  = STALL_W'(3'b111);
  localparam logic [CNT_W-1:0]   c_CNT_MAX   = '1;

  logic [1:0]         state_q, state_d;
  logic               mdu_busy_q, mdu_busy_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, lu_cnt_q;
  logic [STALL_W-1:0] w_stall;

  logic w_mem_pend;
  logic w_mem_stall;
  logic w_mdu_stall;
  logic w_mdu_new;
  logic w_timeout_hit;

  // An ack or ready releases the pipeline in the same cycle it arrives.
  assign w_mem_pend    = dmem_req_i && !dmem_ack_i;
  assign w_mem_stall   = ((state_q == c_MEM_WAIT) || dmem_req_i) && !dmem_ack_i;
  assign w_mdu_stall   = (mdu_busy_q || mdu_start_i) && !mdu_ready_i;
  // A start while an operation is already outstanding is ignored.
  assign w_mdu_new     = mdu_start_i && !mdu_ready_i && !mdu_busy_q;
  assign w_timeout_hit = mdu_busy_q && !mdu_ready_i && (timer_q == c_TMR_LAST);

  // Priority-encode the stall bus; the older (later) stage wins.
  always_comb begin
    w_stall = '0;
    if (w_mem_stall) begin
      w_stall = c_STALL_MEM;
    end else if (w_mdu_stall) begin
      w_stall = c_STALL_MDU;
    end else if (stallreq_id_i) begin
      w_stall = c_STALL_LU;
    end
  end

  // Next-state logic for MDU occupancy, watchdog and wait FSM.
  always_comb begin
    mdu_busy_d = mdu_busy_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    state_d    = state_q;

    if (w_mdu_new) begin
      mdu_busy_d = 1'b1;
      timer_d    = '0;
    end else if (mdu_busy_q) begin
      if (mdu_ready_i) begin
        mdu_busy_d = 1'b0;
        timer_d    = '0;
      end else if (w_timeout_hit) begin
        mdu_busy_d = 1'b0;
        timer_d    = '0;
        timeout_d  = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    case (state_q)
      c_IDLE: begin
        if (w_mem_pend) begin
          state_d = c_MEM_WAIT;
        end else if (w_mdu_new) begin
          state_d = c_MDU_WAIT;
        end
      end
      c_MDU_WAIT: begin
        if (w_mem_pend) begin
          state_d = c_MEM_WAIT;
        end else if (mdu_ready_i) begin
          state_d = c_IDLE;
        end
      end
      c_MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = mdu_busy_d ? c_MDU_WAIT : c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase

    // MDU_WAIT only makes sense with an operation outstanding; this is
    // what returns the FSM to IDLE when the watchdog fires. A timeout during
    // a memory wait leaves the memory wait in place.
    if ((state_d == c_MDU_WAIT) && !mdu_busy_d) begin
      state_d = c_IDLE;
    end
  end

  // State, occupancy and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_IDLE;
      mdu_busy_q <= 1'b0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdu_busy_q <= mdu_busy_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
    end
  end

  // Saturating stall-cycle performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if ((w_stall != '0) && (stall_cnt_q != c_CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((w_stall == c_STALL_LU) && (lu_cnt_q != c_CNT_MAX)) begin
        lu_cnt_q <= lu_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_o        = w_stall;
  assign mdu_busy_o     = mdu_busy_q;
  assign mdu_timeout_o  = timeout_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign lu_stall_cnt_o = lu_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_stall_ctrl                                         |
// | Description : Self-checking bench for pipe_stall_ctrl: directed cases    |
// |               plus randomized traffic against a behavioural model.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

  localparam int STALL_W     = 6;
  localparam int MDU_TIMEOUT = 64;
  localparam int CNT_W       = 10;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stallreq_id_i = 1'b0;
  logic               mdu_start_i   = 1'b0;
  logic               mdu_ready_i   = 1'b0;
  logic               dmem_req_i    = 1'b0;
  logic               dmem_ack_i    = 1'b0;
  logic [STALL_W-1:0] stall_o;
  logic               mdu_busy_o;
  logic               mdu_timeout_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [CNT_W-1:0]   lu_stall_cnt_o;

  pipe_stall_ctrl #(
    .STALL_W    (STALL_W),
    .MDU_TIMEOUT(MDU_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .mdu_start_i   (mdu_start_i),
    .mdu_ready_i   (mdu_ready_i),
    .dmem_req_i    (dmem_req_i),
    .dmem_ack_i    (dmem_ack_i),
    .stall_o       (stall_o),
    .mdu_busy_o    (mdu_busy_o),
    .mdu_timeout_o (mdu_timeout_o),
    .stall_cnt_o   (stall_cnt_o),
    .lu_stall_cnt_o(lu_stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a memory wait is open from an unacked request until
  // its ack; an MDU operation is open from an unfinished start until ready
  // or until it has been outstanding for MDU_TIMEOUT cycles.
  bit m_mem, m_busy, m_to;
  int m_age, m_cnt, m_lu;

  // Observed outputs of the most recent step, for directed spot checks.
  logic [STALL_W-1:0] o_stall;
  logic               o_busy, o_to;
  logic [CNT_W-1:0]   o_cnt, o_lu;

  function automatic logic [5:0] ref_stall(input bit id, st, rdy, req, ack);
    if ((m_mem || req) && !ack)     return 6'b011111;
    if ((m_busy || st) && !rdy)     return 6'b001111;
    if (id)                         return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_mem = 0; m_busy = 0; m_to = 0;
    m_age = 0; m_cnt = 0; m_lu = 0;
  endtask

  task automatic do_reset();
    stallreq_id_i = 0; mdu_start_i = 0; mdu_ready_i = 0;
    dmem_req_i = 0; dmem_ack_i = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check every output mid-cycle, advance model.
  task automatic step(input bit id, input bit st, input bit rdy, input bit req, input bit ack);
    logic [5:0] e;
    stallreq_id_i = id; mdu_start_i = st; mdu_ready_i = rdy;
    dmem_req_i = req; dmem_ack_i = ack;
    @(negedge clk);
    e = ref_stall(id, st, rdy, req, ack);
    o_stall = stall_o; o_busy = mdu_busy_o; o_to = mdu_timeout_o;
    o_cnt = stall_cnt_o; o_lu = lu_stall_cnt_o;
    chk("stall",     32'(stall_o),        32'(e));
    chk("mdu_busy",  32'(mdu_busy_o),     32'(m_busy));
    chk("timeout",   32'(mdu_timeout_o),  32'(m_to));
    chk("stall_cnt", 32'(stall_cnt_o),    32'(m_cnt));
    chk("lu_cnt",    32'(lu_stall_cnt_o), 32'(m_lu));
    @(posedge clk);
    if (e != 6'b0 && m_cnt < CNT_MAX) m_cnt++;
    if (e == 6'b000111 && m_lu < CNT_MAX) m_lu++;
    if (m_mem) begin
      if (ack) m_mem = 0;
    end else if (req && !ack) begin
      m_mem = 1;
    end
    if (!m_busy) begin
      if (st && !rdy) begin
        m_busy = 1;
        m_age  = 0;
      end
    end else if (rdy) begin
      m_busy = 0;
    end else begin
      m_age++;
      if (m_age == MDU_TIMEOUT) begin
        m_busy = 0;
        m_to   = 1;
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset state
    step(0, 0, 0, 0, 0);
    chk("rst_stall", 32'(o_stall), 32'h0);
    chk("rst_cnt",   32'(o_cnt),   32'h0);

    // Single-cycle load-use
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("lu_stall", 32'(o_stall), 32'h07);
    step(0, 0, 0, 0, 0);
    chk("lu_after", 32'(o_stall), 32'h00);
    chk("lu_cnt1",  32'(o_lu),    32'd1);
    chk("st_cnt1",  32'(o_cnt),   32'd1);

    // Load-use together with MDU start: MDU wins
    do_reset();
    step(1, 1, 0, 0, 0);
    chk("prio_stall", 32'(o_stall), 32'h0f);
    step(0, 0, 1, 0, 0);
    chk("prio_lu", 32'(o_lu), 32'd0);

    // Single-cycle MDU: no stall, no busy
    do_reset();
    step(0, 1, 1, 0, 0);
    chk("mdu1_stall", 32'(o_stall), 32'h0);
    step(0, 0, 0, 0, 0);
    chk("mdu1_busy", 32'(o_busy), 32'h0);

    // 33-cycle MDU operation
    do_reset();
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 32; i++) step(0, 0, 0, 0, 0);
    chk("mdu_c32", 32'(o_stall), 32'h0f);
    step(0, 0, 1, 0, 0);
    chk("mdu_c33_stall", 32'(o_stall), 32'h0);
    chk("mdu_c33_busy",  32'(o_busy),  32'h1);
    step(0, 0, 0, 0, 0);
    chk("mdu_c34_busy",  32'(o_busy),  32'h0);

    // Memory wait overlapping an outstanding MDU
    do_reset();
    step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      chk("ovl_mem", 32'(o_stall), 32'h1f);
    end
    step(0, 0, 0, 1, 1);
    chk("ovl_ack", 32'(o_stall), 32'h0f);
    repeat (2) step(0, 0, 0, 0, 0);
    chk("ovl_mdu", 32'(o_stall), 32'h0f);
    step(0, 0, 1, 0, 0);
    chk("ovl_rdy", 32'(o_stall), 32'h0);

    // MDU watchdog
    do_reset();
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= MDU_TIMEOUT; i++) step(0, 0, 0, 0, 0);
    chk("to_pre_busy", 32'(o_busy), 32'h1);
    chk("to_pre_flag", 32'(o_to),   32'h0);
    step(0, 0, 0, 0, 0);
    chk("to_flag",  32'(o_to),    32'h1);
    chk("to_busy",  32'(o_busy),  32'h0);
    chk("to_stall", 32'(o_stall), 32'h0);
    repeat (3) step(1, 0, 0, 0, 0);
    chk("to_sticky", 32'(o_to), 32'h1);

    // Reset in the middle of a memory wait
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0, 0);
    chk("rmw_stall", 32'(o_stall), 32'h0);
    chk("rmw_cnt",   32'(o_cnt),   32'h0);
    chk("rmw_busy",  32'(o_busy),  32'h0);
    step(0, 0, 0, 0, 1);
    chk("rmw_idle", 32'(o_stall), 32'h0);

    // Counter saturation
    do_reset();
    repeat (CNT_MAX + 8) step(1, 0, 0, 0, 0);
    chk("sat_lu",  32'(o_lu),  32'(CNT_MAX));
    chk("sat_cnt", 32'(o_cnt), 32'(CNT_MAX));

    // Randomized traffic; round 1 never completes the MDU so the watchdog fires
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 700; c++) begin
        step(($urandom % 4) == 0,
             ($urandom % 10) == 0,
             (r != 1) && (($urandom % 8) == 0),
             ($urandom % 3) == 0,
             ($urandom % 3) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
